// File: rtl/fetch_unit_if.sv
// Fetch-side bus: instruction-memory port, hazard/redirect inputs and the IF/ID register outputs.
interface fetch_unit_if;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        if_id_valid;

  modport master (
    output pc, if_id_pc, if_id_instr, if_id_valid,
    input  instr, stall, branch_taken, branch_target
  );

  modport slave (
    input  pc, if_id_pc, if_id_instr, if_id_valid,
    output instr, stall, branch_taken, branch_target
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC sequencing with redirect/stall/halt and the IF/ID pipeline register.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4,
  parameter logic [31:0] PC_LAST  = 32'd252,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.master bus,
  output logic         halted,
  output logic [31:0]  fetch_count
);

  typedef enum logic {RUN, HALT} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic [31:0] count_q, count_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= RUN;
      pc_q         <= RESET_PC;
      ifid_pc_q    <= '0;
      ifid_instr_q <= NOP;
      ifid_valid_q <= 1'b0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_valid_q <= ifid_valid_d;
      count_q      <= count_d;
    end
  end

  // Everything holds by default; HALT relies on that, since IF/ID already holds the bubble.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_valid_d = ifid_valid_q;
    count_d      = count_q;
    case (state_q)
      RUN: begin
        if (bus.branch_taken) begin
          pc_d         = {bus.branch_target[31:2], 2'b00};
          ifid_pc_d    = '0;
          ifid_instr_d = NOP;
          ifid_valid_d = 1'b0;
        end else if (bus.stall) begin
          pc_d = pc_q;
        end else if (bus.instr == 32'h0000_0000) begin
          state_d      = HALT;
          ifid_pc_d    = '0;
          ifid_instr_d = NOP;
          ifid_valid_d = 1'b0;
        end else begin
          pc_d         = (pc_q == PC_LAST) ? RESET_PC : pc_q + PC_STEP;
          ifid_pc_d    = pc_q;
          ifid_instr_d = bus.instr;
          ifid_valid_d = 1'b1;
          if (count_q != '1) count_d = count_q + 32'd1;
        end
      end
      HALT: state_d = HALT;
      default: state_d = RUN;
    endcase
  end

  assign bus.pc          = pc_q;
  assign bus.if_id_pc    = ifid_pc_q;
  assign bus.if_id_instr = ifid_instr_q;
  assign bus.if_id_valid = ifid_valid_q;
  assign halted          = (state_q == HALT);
  assign fetch_count     = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequencing, stall, branch flush, wrap, halt and async reset.
module tb_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        halted;
  logic [31:0] fetch_count;
  logic [31:0] mem [0:63];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  fetch_unit_if bus ();

  fetch_unit u_dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus.master),
    .halted      (halted),
    .fetch_count (fetch_count)
  );

  always #5 clk = ~clk;

  assign bus.instr = mem[bus.pc[7:2]];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 | (32'(i) << 2);
    reset             = 1'b1;
    bus.stall         = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.branch_target = '0;
    #12;
    check("rst_pc", bus.pc, 32'd0);
    check("rst_valid", {31'd0, bus.if_id_valid}, 32'd0);
    check("rst_instr", bus.if_id_instr, NOP);
    check("rst_ifid_pc", bus.if_id_pc, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_count", fetch_count, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    step();
    check("seq1_pc", bus.pc, 32'd4);
    check("seq1_ifid_pc", bus.if_id_pc, 32'd0);
    check("seq1_valid", {31'd0, bus.if_id_valid}, 32'd1);
    check("seq1_instr", bus.if_id_instr, 32'hA000_0000);
    step();
    check("seq2_pc", bus.pc, 32'd8);
    check("seq2_ifid_pc", bus.if_id_pc, 32'd4);

    bus.stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      check("stall_pc", bus.pc, 32'd8);
      check("stall_ifid_pc", bus.if_id_pc, 32'd4);
      check("stall_instr", bus.if_id_instr, 32'hA000_0004);
      check("stall_count", fetch_count, 32'd2);
    end
    bus.stall = 1'b0;
    step();
    check("unstall_pc", bus.pc, 32'd12);
    check("unstall_ifid_pc", bus.if_id_pc, 32'd8);
    check("seq3_count", fetch_count, 32'd3);
    step();
    check("seq4_pc", bus.pc, 32'd16);

    bus.stall         = 1'b1;
    bus.branch_taken  = 1'b1;
    bus.branch_target = 32'h0000_0027;
    step();
    bus.stall        = 1'b0;
    bus.branch_taken = 1'b0;
    check("br_pc", bus.pc, 32'd36);
    check("br_valid", {31'd0, bus.if_id_valid}, 32'd0);
    check("br_instr", bus.if_id_instr, NOP);
    check("br_count", fetch_count, 32'd4);
    step();
    check("br_ifid_pc", bus.if_id_pc, 32'd36);
    check("br_next_pc", bus.pc, 32'd40);
    check("br_next_count", fetch_count, 32'd5);

    #2;
    reset = 1'b1;
    #1;
    check("async_pc", bus.pc, 32'd0);
    check("async_valid", {31'd0, bus.if_id_valid}, 32'd0);
    check("async_count", fetch_count, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 63; i++) step();
    check("pre_wrap_pc", bus.pc, 32'd252);
    step();
    check("wrap_pc", bus.pc, 32'd0);
    check("wrap_ifid_pc", bus.if_id_pc, 32'd252);
    check("wrap_count", fetch_count, 32'd64);

    mem[5] = 32'h0000_0000;
    for (int i = 0; i < 5; i++) step();
    check("pre_halt_pc", bus.pc, 32'd20);
    check("pre_halt_halted", {31'd0, halted}, 32'd0);
    step();
    check("halt_pc", bus.pc, 32'd20);
    check("halt_halted", {31'd0, halted}, 32'd1);
    check("halt_valid", {31'd0, bus.if_id_valid}, 32'd0);
    check("halt_instr", bus.if_id_instr, NOP);
    check("halt_count", fetch_count, 32'd69);
    bus.branch_taken  = 1'b1;
    bus.branch_target = 32'h0000_0080;
    step();
    step();
    bus.branch_taken = 1'b0;
    check("halt_br_pc", bus.pc, 32'd20);
    check("halt_br_halted", {31'd0, halted}, 32'd1);
    check("halt_br_valid", {31'd0, bus.if_id_valid}, 32'd0);

    @(negedge clk);
    reset = 1'b1;
    #1;
    check("halt_rst_pc", bus.pc, 32'd0);
    check("halt_rst_halted", {31'd0, halted}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    step();
    check("post_rst_pc", bus.pc, 32'd4);
    check("post_rst_instr", bus.if_id_instr, 32'hA000_0000);
    check("post_rst_count", fetch_count, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 SHALL have parameter PC_STEP, default 4, the sequential PC increment.
REQ-003 SHALL have parameter PC_LAST, default 252, the last valid fetch address; the sequential successor of PC_LAST is RESET_PC.
REQ-004 SHALL have parameter NOP, default 32'h0000_0013 (addi x0,x0,0), the bubble instruction.
REQ-005 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-007 SHALL have port pc, output, 32, the current fetch address driven to instruction memory.
REQ-008 SHALL have port instr, input, 32, the combinational instruction-memory read data for pc.
REQ-009 SHALL have port stall, input, 1, hazard-unit request to freeze the PC and IF/ID.
REQ-010 SHALL have port branch_taken, input, 1, redirect request from the resolving stage.
REQ-011 SHALL have port branch_target, input, 32, the redirect address.
REQ-012 SHALL have port if_id_pc, output, 32, registered PC of the decoded instruction.
REQ-013 SHALL have port if_id_instr, output, 32, registered instruction to decode.
REQ-014 SHALL have port if_id_valid, output, 1, high when if_id_instr is a real fetched instruction.
REQ-015 SHALL have port halted, output, 1, high in HALT state.
REQ-016 SHALL have port fetch_count, output, 32, number of valid instructions delivered to IF/ID.

Function
REQ-017 SHALL implement two states, RUN and HALT; HALT is left only by reset.
REQ-018 In RUN, each cycle SHALL apply the first matching rule, priority branch_taken > stall > halt detect > sequential.
REQ-019 branch_taken: pc <= {branch_target[31:2],2'b00}; IF/ID loads if_id_instr=NOP, if_id_pc=0, if_id_valid=0 (flush), stall ignored.
REQ-020 stall (no branch): pc, if_id_pc, if_id_instr, if_id_valid, fetch_count all hold.
REQ-021 Halt detect: instr == 32'h0000_0000 -> next state HALT; pc holds; IF/ID loads NOP with if_id_valid=0.
REQ-022 Sequential: IF/ID loads if_id_pc=pc, if_id_instr=instr, if_id_valid=1; pc <= (pc==PC_LAST) ? RESET_PC : pc+PC_STEP, modulo 2^32.
REQ-023 In HALT: pc holds, IF/ID holds NOP with valid=0, stall and branch_taken ignored, halted=1.
REQ-024 fetch_count SHALL increment by 1 exactly on cycles where IF/ID loads with if_id_valid=1, saturating at 32'hFFFF_FFFF.
REQ-025 pc SHALL be a registered output; if_id_instr latency from pc is one clock edge.
REQ-026 halted SHALL assert in the cycle after the halt-detecting edge and remain asserted.

Reset
REQ-027 On reset assertion, asynchronously: pc=RESET_PC, if_id_pc=0, if_id_instr=NOP, if_id_valid=0, halted=0, fetch_count=0, state RUN.
REQ-028 Reset asserted mid-stall, mid-branch or in HALT SHALL discard all pending requests; first fetch after release is RESET_PC.

Verification
REQ-029 Release reset, memory words 0,4,8 nonzero, no stall/branch -> pc 0,4,8,12 on successive edges; if_id_pc 0,4,8; if_id_valid=1 from first edge; fetch_count=3 after 3 edges.
REQ-030 pc=8, stall high 2 cycles -> pc stays 8, IF/ID holds instruction at 4, fetch_count unchanged; after release pc=12.
REQ-031 pc=16, branch_taken=1, stall=1, branch_target=32'h0000_0027 -> next pc=36, if_id_valid=0, if_id_instr=NOP; following edge if_id_pc=36.
REQ-032 pc=PC_LAST=252, nonzero instr -> next pc=0, if_id_pc=252.
REQ-033 instr at pc=20 is 32'h0 -> pc stays 20, halted=1, if_id_valid=0; later branch_taken ignored; reset -> pc=0, halted=0.
REQ-034 Assert reset asynchronously between clock edges while pc=40 -> pc=0 and if_id_valid=0 immediately, before next clk edge.
